// File: rtl/apple1_char_receiver_if.sv
// rtl/apple1_char_receiver_if.sv - host character handshake and display-write bundle
interface apple1_char_receiver_if;
  logic       da;
  logic [6:0] d;
  logic       write_slot;
  logic       rda;
  logic [5:0] char_q;
  logic       char_we;
  logic       newline_stb;

  modport master (
    output da, d, write_slot,
    input  rda, char_q, char_we, newline_stb
  );

  modport slave (
    input  da, d, write_slot,
    output rda, char_q, char_we, newline_stb
  );
endinterface

// File: rtl/apple1_char_receiver.sv
// rtl/apple1_char_receiver.sv - Apple-1 PIA port-B character receiver
module apple1_char_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int RDA_HOLD    = 4
) (
  input logic                   clk,
  input logic                   clr_n,
  apple1_char_receiver_if.slave bus
);
  localparam int CW = $clog2(RDA_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RDA_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SLOT,
    WRITE,
    HOLD,
    RELEASE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] da_sync;
  logic                   da_prev;
  logic                   da_s;
  logic                   da_rise;
  logic                   kind_nl;
  logic [5:0]             code;
  logic [CW-1:0]          hold_cnt;
  logic                   rda_r;
  logic                   we_r;
  logic                   nl_r;
  logic [5:0]             char_q_r;

  assign da_s    = da_sync[SYNC_STAGES-1];
  assign da_rise = da_s & ~da_prev;

  assign bus.rda         = rda_r;
  assign bus.char_we     = we_r;
  assign bus.newline_stb = nl_r;
  assign bus.char_q      = char_q_r;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      da_sync  <= '0;
      da_prev  <= 1'b0;
      kind_nl  <= 1'b0;
      code     <= '0;
      hold_cnt <= '0;
      rda_r    <= 1'b1;
      we_r     <= 1'b0;
      nl_r     <= 1'b0;
      char_q_r <= '0;
    end else begin
      da_sync <= {da_sync[SYNC_STAGES-2:0], bus.da};
      da_prev <= da_s;
      case (state)
        IDLE: begin
          if (da_rise) begin
            rda_r <= 1'b0;
            // Classification happens on the capture edge; char_q itself only
            // changes on the write so it keeps the last displayed code.
            if (bus.d == 7'h0D) begin
              kind_nl <= 1'b1;
              state   <= WAIT_SLOT;
            end else if (bus.d >= 7'h20 && bus.d <= 7'h5F) begin
              kind_nl <= 1'b0;
              code    <= bus.d[5:0];
              state   <= WAIT_SLOT;
            end else if (bus.d >= 7'h60 && bus.d <= 7'h7E) begin
              kind_nl <= 1'b0;
              code    <= {1'b0, bus.d[4:0]};
              state   <= WAIT_SLOT;
            end else begin
              hold_cnt <= '0;
              state    <= HOLD;
            end
          end
        end
        WAIT_SLOT: begin
          if (bus.write_slot) begin
            state <= WRITE;
            if (kind_nl) begin
              nl_r <= 1'b1;
            end else begin
              we_r     <= 1'b1;
              char_q_r <= code;
            end
          end
        end
        WRITE: begin
          we_r     <= 1'b0;
          nl_r     <= 1'b0;
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          // Host must also drop da before we re-arm, so a held strobe never re-triggers.
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CW'(1);
          end else if (!da_s) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          rda_r <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apple1_char_receiver.sv
// tb/tb_apple1_char_receiver.sv - directed bench for apple1_char_receiver
module tb_apple1_char_receiver;
  localparam int SYNC_STAGES = 2;
  localparam int RDA_HOLD    = 4;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  apple1_char_receiver_if bus();

  apple1_char_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .RDA_HOLD   (RDA_HOLD)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int nl_cnt   = 0;
  int both_cnt = 0;
  logic [5:0] last_q = '0;

  // Strobe monitor on the falling edge, away from the registered update.
  always @(negedge clk) begin
    if (bus.char_we === 1'b1) begin
      we_cnt++;
      last_q = bus.char_q;
    end
    if (bus.newline_stb === 1'b1) nl_cnt++;
    if (bus.char_we === 1'b1 && bus.newline_stb === 1'b1) both_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_rda(input logic val, input int max, output int n);
    n = 0;
    while (bus.rda !== val && n < max) begin
      step(1);
      n++;
    end
    if (bus.rda !== val) n = -1;
  endtask

  task automatic transact(input logic [6:0] code, output int t_low, output int t_high);
    bus.d  = code;
    bus.da = 1'b1;
    wait_rda(1'b0, 10, t_low);
    step(3);
    bus.write_slot = 1'b1;
    step(1);
    bus.write_slot = 1'b0;
    step(2);
    bus.da = 1'b0;
    wait_rda(1'b1, 30, t_high);
    step(2);
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    step(3);
    clr_n = 1'b1;
    step(1);
    checks++; if (bus.rda !== 1'b1) begin failures++; $display("FAIL reset_rda got=%b exp=1", bus.rda); end
    checks++; if (bus.char_we !== 1'b0) begin failures++; $display("FAIL reset_char_we got=%b exp=0", bus.char_we); end
    checks++; if (bus.newline_stb !== 1'b0) begin failures++; $display("FAIL reset_newline got=%b exp=0", bus.newline_stb); end
    checks++; if (bus.char_q !== 6'h00) begin failures++; $display("FAIL reset_char_q got=%h exp=00", bus.char_q); end
    step(10);
    checks++; if (bus.rda !== 1'b1 || we_cnt != 0 || nl_cnt != 0) begin
      failures++; $display("FAIL idle_quiet rda=%b we=%0d nl=%0d exp rda=1 we=0 nl=0", bus.rda, we_cnt, nl_cnt);
    end
  endtask

  task automatic test_printable;
    int n;
    int we0;
    we0 = we_cnt;
    bus.d  = 7'h41;
    bus.da = 1'b1;
    step(SYNC_STAGES);
    checks++; if (bus.rda !== 1'b1) begin failures++; $display("FAIL rda_not_early got=%b exp=1", bus.rda); end
    step(1);
    checks++; if (bus.rda !== 1'b0) begin failures++; $display("FAIL rda_drop got=%b exp=0", bus.rda); end
    step(7);
    checks++; if (we_cnt != we0) begin failures++; $display("FAIL no_we_before_slot got=%0d exp=%0d", we_cnt, we0); end
    bus.write_slot = 1'b1;
    step(1);
    bus.write_slot = 1'b0;
    checks++; if (bus.char_we !== 1'b1 || bus.char_q !== 6'h01) begin
      failures++; $display("FAIL printable_write we=%b q=%h exp we=1 q=01", bus.char_we, bus.char_q);
    end
    step(1);
    checks++; if (bus.char_we !== 1'b0 || we_cnt != we0 + 1) begin
      failures++; $display("FAIL printable_one_cycle we=%b count=%0d exp we=0 count=%0d", bus.char_we, we_cnt - we0, 1);
    end
    bus.da = 1'b0;
    wait_rda(1'b1, 30, n);
    checks++; if (n < RDA_HOLD + 1) begin
      failures++; $display("FAIL rda_release_delay got=%0d exp>=%0d", n, RDA_HOLD + 1);
    end
    step(2);
  endtask

  task automatic test_fold_cr;
    int tl, th, we0, nl0;
    we0 = we_cnt; nl0 = nl_cnt;
    transact(7'h61, tl, th);
    checks++; if (tl < 0 || th < 0) begin failures++; $display("FAIL fold_handshake low=%0d high=%0d exp>=0", tl, th); end
    checks++; if (we_cnt - we0 != 1 || last_q !== 6'h01 || nl_cnt != nl0) begin
      failures++; $display("FAIL fold_write we=%0d q=%h nl=%0d exp we=1 q=01 nl=0", we_cnt - we0, last_q, nl_cnt - nl0);
    end
    we0 = we_cnt; nl0 = nl_cnt;
    transact(7'h0D, tl, th);
    checks++; if (nl_cnt - nl0 != 1 || we_cnt != we0) begin
      failures++; $display("FAIL cr_newline nl=%0d we=%0d exp nl=1 we=0", nl_cnt - nl0, we_cnt - we0);
    end
    checks++; if (bus.char_q !== 6'h01) begin failures++; $display("FAIL char_q_hold got=%h exp=01", bus.char_q); end
  endtask

  task automatic test_discard;
    logic [6:0] codes [2];
    int n, we0, nl0;
    codes[0] = 7'h07;
    codes[1] = 7'h7F;
    for (int i = 0; i < 2; i++) begin
      we0 = we_cnt; nl0 = nl_cnt;
      bus.d  = codes[i];
      bus.da = 1'b1;
      wait_rda(1'b0, 10, n);
      checks++; if (n < 0) begin failures++; $display("FAIL discard_rda_drop code=%h got=timeout", codes[i]); end
      bus.da = 1'b0;
      n = 0;
      while (bus.rda !== 1'b1 && n < 30) begin
        bus.write_slot = ~bus.write_slot;
        step(1);
        n++;
      end
      bus.write_slot = 1'b0;
      checks++; if (bus.rda !== 1'b1 || n < RDA_HOLD + 1 || n > RDA_HOLD + 3) begin
        failures++; $display("FAIL discard_rda_low code=%h cycles=%0d exp=%0d..%0d", codes[i], n, RDA_HOLD + 1, RDA_HOLD + 3);
      end
      step(3);
      checks++; if (we_cnt != we0 || nl_cnt != nl0) begin
        failures++; $display("FAIL discard_no_strobe code=%h we=%0d nl=%0d exp 0 0", codes[i], we_cnt - we0, nl_cnt - nl0);
      end
    end
  endtask

  task automatic test_abuse;
    int n, we0, nl0;
    we0 = we_cnt;
    bus.d  = 7'h45;
    bus.da = 1'b1;
    wait_rda(1'b0, 10, n);
    checks++; if (n < 0) begin failures++; $display("FAIL abuse_rda_drop got=timeout"); end
    // Fall then a second rise with a new code while waiting for the slot.
    step(1);
    bus.da = 1'b0;
    step(3);
    bus.d  = 7'h46;
    bus.da = 1'b1;
    step(3);
    bus.write_slot = 1'b1;
    step(1);
    bus.write_slot = 1'b0;
    step(1);
    checks++; if (we_cnt - we0 != 1 || last_q !== 6'h05) begin
      failures++; $display("FAIL abuse_first_char we=%0d q=%h exp we=1 q=05", we_cnt - we0, last_q);
    end
    step(50);
    checks++; if (bus.rda !== 1'b0 || we_cnt - we0 != 1) begin
      failures++; $display("FAIL da_held_rda rda=%b we=%0d exp rda=0 we=1", bus.rda, we_cnt - we0);
    end
    bus.da = 1'b0;
    wait_rda(1'b1, 30, n);
    checks++; if (n < 0) begin failures++; $display("FAIL abuse_release got=timeout"); end
    we0 = we_cnt; nl0 = nl_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.write_slot = 1'b1;
      step(1);
      bus.write_slot = 1'b0;
      step(1);
    end
    checks++; if (we_cnt != we0 || nl_cnt != nl0 || bus.rda !== 1'b1) begin
      failures++; $display("FAIL idle_slot_ignored we=%0d nl=%0d rda=%b exp 0 0 1", we_cnt - we0, nl_cnt - nl0, bus.rda);
    end
  endtask

  task automatic test_reset_mid;
    int n, tl, th, we0;
    we0 = we_cnt;
    bus.d  = 7'h42;
    bus.da = 1'b1;
    wait_rda(1'b0, 10, n);
    checks++; if (n < 0) begin failures++; $display("FAIL mid_rda_drop got=timeout"); end
    step(2);
    clr_n = 1'b0;
    #1;
    checks++; if (bus.rda !== 1'b1 || bus.char_q !== 6'h00) begin
      failures++; $display("FAIL async_reset rda=%b q=%h exp rda=1 q=00", bus.rda, bus.char_q);
    end
    #1;
    bus.write_slot = 1'b1;
    step(1);
    bus.write_slot = 1'b0;
    bus.da = 1'b0;
    step(2);
    clr_n = 1'b1;
    step(4);
    checks++; if (we_cnt != we0 || bus.rda !== 1'b1) begin
      failures++; $display("FAIL dropped_char we=%0d rda=%b exp we=0 rda=1", we_cnt - we0, bus.rda);
    end
    transact(7'h43, tl, th);
    checks++; if (we_cnt - we0 != 1 || bus.char_q !== 6'h03) begin
      failures++; $display("FAIL post_reset_write we=%0d q=%h exp we=1 q=03", we_cnt - we0, bus.char_q);
    end
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL both_strobes got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    bus.da         = 1'b0;
    bus.d          = 7'h00;
    bus.write_slot = 1'b0;
    test_reset();
    test_printable();
    test_fold_cr();
    test_discard();
    test_abuse();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
